reg_file_sb: RTL

Parametrised multi-read-port integer register file with a per-register busy scoreboard, the successor to the single-cycle core's 2R/1W register file. It serves the pipelined core: decode reads operands and reserves the destination register, and writeback writes the result and releases the reservation. Register 0 is hardwired to zero. Optional write-to-read bypass removes the writeback/decode hazard.

---
 rtl/reg_file_sb.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port integer register file with per-register busy scoreboard
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ok,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec,
    output logic [AW:0]         busy_cnt
);

    // Entry 0 is only ever cleared by reset; reads of x0 are forced to zero anyway.
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_next;
    logic             wr_hit;

    assign wr_hit = wr_en && (wr_addr != '0);

    // A write to the register being reserved frees it in the same cycle.
    assign rsv_ok = rsv_en && !flush &&
                    ((rsv_addr == '0) || !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

    always_comb begin
        busy_next = busy;
        if (wr_hit) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (rsv_ok && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy <= busy_next;
            cnt  <= cnt_next;
            if (wr_hit) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    assign busy_vec = busy;
    assign busy_cnt = cnt;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[p*AW +: AW];

        always_comb begin
            d = regs[a];
            b = busy[a];
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
                d = wr_data;
                b = 1'b0;
            end
        end

        assign rd_data[p*XLEN +: XLEN] = d;
        assign rd_busy[p]              = b;
    end

endmodule
